// File: rtl/router_reg_pkt.sv
// rtl/router_reg_pkt.sv - router datapath register block: header capture, byte steering,
// holding buffer for stalled bytes, integrity/length/overflow checks.
module router_reg_pkt #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 2,
  parameter int HOLD_DEPTH  = 2,
  parameter int PARITY_MODE = 0,
  localparam int CW         = $clog2(HOLD_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_packet_valid,
  output logic              error,
  output logic              len_err,
  output logic              ovf_err,
  output logic              hold_empty,
  output logic [CW-1:0]     hold_count
);

  localparam int LW = DATA_W - ADDR_W;
  localparam int PW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(HOLD_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  function automatic logic [DATA_W-1:0] combine(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    if (PARITY_MODE == 1) return a + b;
    return a ^ b;
  endfunction

  logic [DATA_W-1:0] header_q, header_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] ext_q, ext_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic              pd_q, pd_d;
  logic              lpv_q, lpv_d;
  logic              err_q, err_d;
  logic              len_q, len_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] hold_q [HOLD_DEPTH];
  logic [DATA_W-1:0] hold_d [HOLD_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     hcnt_q, hcnt_d;

  logic st_dec, st_lfd, st_ld, st_laf;
  logic hold_full, accept;

  // full_state freezes the datapath; remaining state inputs resolve by priority.
  assign st_dec = detect_add & ~full_state;
  assign st_lfd = lfd_state & ~detect_add & ~full_state;
  assign st_ld  = ld_state & ~lfd_state & ~detect_add & ~full_state;
  assign st_laf = laf_state & ~ld_state & ~lfd_state & ~detect_add & ~full_state;

  assign hold_full = (hcnt_q == CW'(HOLD_DEPTH));
  assign accept    = ~fifo_full | ~hold_full;

  always_comb begin
    header_d = header_q;
    dout_d   = dout_q;
    acc_d    = acc_q;
    ext_d    = ext_q;
    cnt_d    = cnt_q;
    pd_d     = pd_q;
    lpv_d    = lpv_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    hold_d   = hold_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hcnt_d   = hcnt_q;
    err_d    = pd_q & (acc_q != ext_q);

    if (st_dec) begin
      acc_d    = '0;
      ext_d    = '0;
      cnt_d    = '0;
      pd_d     = 1'b0;
      len_d    = 1'b0;
      ovf_d    = 1'b0;
      hcnt_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      if (pkt_valid && (data_in[ADDR_W-1:0] != '1)) header_d = data_in;
    end else if (st_lfd) begin
      dout_d = header_q;
      acc_d  = header_q;
    end else if (st_ld) begin
      if (!fifo_full) begin
        dout_d = data_in;
      end else if (!hold_full) begin
        hold_d[wr_ptr_q] = data_in;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
        hcnt_d           = hcnt_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
      if (accept) begin
        if (pkt_valid) begin
          acc_d = combine(acc_q, data_in);
          if (cnt_q != '1) cnt_d = cnt_q + LW'(1);
        end else begin
          ext_d = data_in;
          pd_d  = 1'b1;
          len_d = (cnt_q != header_q[DATA_W-1:ADDR_W]);
        end
      end
    end else if (st_laf) begin
      if (!fifo_full && (hcnt_q != '0)) begin
        dout_d   = hold_q[rd_ptr_q];
        rd_ptr_d = ptr_inc(rd_ptr_q);
        hcnt_d   = hcnt_q - CW'(1);
      end
    end

    if (rst_int_reg) lpv_d = 1'b0;
    else if (st_ld && !pkt_valid) lpv_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header_q <= '0;
      dout_q   <= '0;
      acc_q    <= '0;
      ext_q    <= '0;
      cnt_q    <= '0;
      pd_q     <= 1'b0;
      lpv_q    <= 1'b0;
      err_q    <= 1'b0;
      len_q    <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < HOLD_DEPTH; i++) hold_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hcnt_q   <= '0;
    end else begin
      header_q <= header_d;
      dout_q   <= dout_d;
      acc_q    <= acc_d;
      ext_q    <= ext_d;
      cnt_q    <= cnt_d;
      pd_q     <= pd_d;
      lpv_q    <= lpv_d;
      err_q    <= err_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hcnt_q   <= hcnt_d;
    end
  end

  assign dout             = dout_q;
  assign parity_done      = pd_q;
  assign low_packet_valid = lpv_q;
  assign error            = err_q;
  assign len_err          = len_q;
  assign ovf_err          = ovf_q;
  assign hold_count       = hcnt_q;
  assign hold_empty       = (hcnt_q == '0);

endmodule
